// File: rtl/sid_mixer_if.sv
// sid_mixer_if: PCM sample stream from the mixer to the DAC/filter path.
//   s_data  - signed 16-bit PCM sample
//   s_valid - s_data holds a sample not yet accepted
//   s_ready - consumer accepts on a clk edge where s_valid && s_ready
interface sid_mixer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sid_mixer.sv
// sid_mixer: sums the three SID voice outputs one voice per clock and scales the
// sum by the master volume. It emits one signed 16-bit PCM sample per clk_en tick.
// Optional feature macro: SID_MIXER_DIGI_DC_EN adds the 6581 volume DC offset
// (vol*DC_STEP) before saturation. Without the macro there is no DC term.
module sid_mixer #(
  parameter int unsigned SHIFT   = 2,
  parameter int unsigned DC_STEP = 512
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        clk_en,
  input  logic [11:0] v1_out,
  input  logic [11:0] v2_out,
  input  logic [11:0] v3_out,
  input  logic [3:0]  r_vol,
  input  logic        r_3off,
  sid_mixer_if.master s_out,
  output logic        busy,
  output logic        ovr,
  input  logic        ovr_clr
);

  localparam int unsigned VW = 12;  // voice sample width
  localparam int unsigned AW = 14;  // accumulator, holds -6144..6141
  localparam int unsigned PW = 18;  // scaled product
  localparam int unsigned SW = 20;  // product plus DC term, pre-saturation
  localparam int unsigned DW = 16;  // PCM output

  localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);

  typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, MUL, WAIT} state_t;

  state_t               state_q, state_d;
  logic [VW-1:0]        v1_q, v2_q, v3_q;
  logic [3:0]           vol_q;
  logic                 off_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_d;
  logic                 busy_d;
  logic                 load_c;
  logic signed [PW-1:0] prod_c, shifted_c;
  logic signed [SW-1:0] sum_c;
  logic [DW-1:0]        sat_c;

  // Re-centre an unsigned voice sample (0x800 = silence) to signed by flipping the MSB.
  function automatic logic signed [AW-1:0] recentre(input logic [VW-1:0] v);
    logic signed [VW-1:0] s;
    s = {~v[VW-1], v[VW-2:0]};
    return AW'(s);
  endfunction

  // Scale, shift, optional DC offset and saturation of the finished accumulator.
  always_comb begin
    prod_c    = PW'(acc_q) * PW'(signed'({1'b0, vol_q}));
    shifted_c = prod_c >>> SHIFT;
`ifdef SID_MIXER_DIGI_DC_EN
    sum_c     = SW'(shifted_c) + signed'(SW'(vol_q) * SW'(DC_STEP));
`else
    sum_c     = SW'(shifted_c);
`endif
    if (sum_c > SAT_MAX) begin
      sat_c = DW'(16'h7FFF);
    end else if (sum_c < SAT_MIN) begin
      sat_c = DW'(16'h8000);
    end else begin
      sat_c = sum_c[DW-1:0];
    end
  end

`ifndef SID_MIXER_DIGI_DC_EN
  // DC_STEP only matters when the digi DC feature is built in.
  logic unused_dc_step;
  assign unused_dc_step = ^32'(DC_STEP);
`endif

  // Next-state and datapath updates. A tick is latched only in IDLE; a tick in any other state sets ovr.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    load_c  = 1'b0;
    ovr_d   = ovr;

    if (clk_en && (state_q != IDLE)) ovr_d = 1'b1;
    if (ovr_clr)                     ovr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (clk_en) begin
          load_c  = 1'b1;
          state_d = ACC1;
        end
      end
      ACC1: begin
        acc_d   = recentre(v1_q);
        state_d = ACC2;
      end
      ACC2: begin
        acc_d   = acc_q + recentre(v2_q);
        state_d = ACC3;
      end
      ACC3: begin
        acc_d   = acc_q + (off_q ? AW'(0) : recentre(v3_q));
        state_d = MUL;
      end
      MUL: begin
        data_d  = sat_c;
        valid_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (s_out.s_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, holding registers and registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
      vol_q   <= '0;
      off_q   <= 1'b0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr     <= ovr_d;
      busy    <= busy_d;
      if (load_c) begin
        v1_q  <= v1_out;
        v2_q  <= v2_out;
        v3_q  <= v3_out;
        vol_q <= r_vol;
        off_q <= r_3off;
      end
    end
  end

  assign s_out.s_data  = data_q;
  assign s_out.s_valid = valid_q;

endmodule

// File: tb/tb_sid_mixer.sv
// tb_sid_mixer: scoreboard bench for sid_mixer. Expected samples are queued when
// a tick is driven and compared when the DUT hands a sample over.
module tb_sid_mixer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        clk_en;
  logic [11:0] v1, v2, v3;
  logic [3:0]  vol;
  logic        off3;
  logic        busy, ovr, ovr_clr;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] sb[$];

  sid_mixer_if bus();

  sid_mixer dut (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .v1_out  (v1),
    .v2_out  (v2),
    .v3_out  (v3),
    .r_vol   (vol),
    .r_3off  (off3),
    .s_out   (bus),
    .busy    (busy),
    .ovr     (ovr),
    .ovr_clr (ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference mixer: recentre, sum, scale, shift, optional DC, saturate.
  function automatic logic [15:0] model(input logic [11:0] a, input logic [11:0] b,
                                        input logic [11:0] c, input logic [3:0] vl,
                                        input logic off);
    int s, p;
    s = (int'(a) - 2048) + (int'(b) - 2048) + (off ? 0 : (int'(c) - 2048));
    p = (s * int'(vl)) >>> 2;
`ifdef SID_MIXER_DIGI_DC_EN
    p = p + int'(vl) * 512;
`endif
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  // Published value for the default build; the DC build uses the model.
  function automatic logic [15:0] spec_exp(input logic [15:0] lit, input logic [11:0] a,
                                           input logic [11:0] b, input logic [11:0] c,
                                           input logic [3:0] vl, input logic off);
`ifdef SID_MIXER_DIGI_DC_EN
    return model(a, b, c, vl, off);
`else
    if (a == b && b == c && vl == 4'd0 && off) return model(a, b, c, vl, off);
    return lit;
`endif
  endfunction

  // Drive one tick; returns #1 after the capturing edge.
  task automatic tick(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                      input logic [3:0] vl, input logic off, input logic push,
                      input logic [15:0] exp);
    @(posedge clk); #1;
    v1 = a; v2 = b; v3 = c; vol = vl; off3 = off; clk_en = 1'b1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    if (push) sb.push_back(exp);
  endtask

  // Count clocks from the tick edge until s_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.s_valid) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  // Accepted-sample monitor.
  always @(negedge clk) begin
    if (n_reset && bus.s_valid && bus.s_ready) begin
      if (sb.size() == 0) begin
        check("spurious_sample", 32'(bus.s_data), 32'hFFFF_FFFF);
      end else begin
        check("sample", 32'(bus.s_data), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int n;
    logic [15:0] e;
    logic [11:0] ra, rb, rc;
    logic [3:0]  rv;
    logic        ro;

    n_reset = 1'b0; clk_en = 1'b0; ovr_clr = 1'b0;
    v1 = 12'h800; v2 = 12'h800; v3 = 12'h800; vol = 4'd0; off3 = 1'b0;
    bus.s_ready = 1'b1;
    #12;
    check("rst_valid", 32'(bus.s_valid), 32'd0);
    check("rst_data",  32'(bus.s_data),  32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ovr",   32'(ovr),         32'd0);
    @(posedge clk); #1; n_reset = 1'b1;

    // Silence, latency and handshake.
    tick(12'h800, 12'h800, 12'h800, 4'd15, 1'b0, 1'b1,
         spec_exp(16'h0000, 12'h800, 12'h800, 12'h800, 4'd15, 1'b0));
    wait_valid(n);
    check("latency", 32'(n), 32'd4);
    check("busy_inflight", 32'(busy), 32'd1);
    drain();
    check("valid_after_hs", 32'(bus.s_valid), 32'd0);

    // Full-scale positive and negative, voice 3 mute.
    tick(12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0, 1'b1,
         spec_exp(16'h59F4, 12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0));
    drain();
    tick(12'h000, 12'h000, 12'h000, 4'd15, 1'b0, 1'b1,
         spec_exp(16'hA600, 12'h000, 12'h000, 12'h000, 4'd15, 1'b0));
    drain();
    tick(12'h800, 12'h800, 12'hFFF, 4'd15, 1'b1, 1'b1,
         spec_exp(16'h0000, 12'h800, 12'h800, 12'hFFF, 4'd15, 1'b1));
    drain();
    tick(12'h800, 12'h800, 12'hFFF, 4'd15, 1'b0, 1'b1,
         spec_exp(16'h1DFC, 12'h800, 12'h800, 12'hFFF, 4'd15, 1'b0));
    drain();

    // Backpressure and overrun.
    bus.s_ready = 1'b0;
    e = model(12'h123, 12'hABC, 12'h7F0, 4'd9, 1'b0);
    tick(12'h123, 12'hABC, 12'h7F0, 4'd9, 1'b0, 1'b1, e);
    wait_valid(n);
    check("bp_latency", 32'(n), 32'd4);
    tick(12'h000, 12'h000, 12'h000, 4'd1, 1'b0, 1'b0, 16'h0000);
    tick(12'hFFF, 12'h000, 12'h000, 4'd2, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    check("ovr_set",    32'(ovr),         32'd1);
    check("bp_valid",   32'(bus.s_valid), 32'd1);
    check("bp_data",    32'(bus.s_data),  32'(e));
    check("bp_busy",    32'(busy),        32'd1);
    @(posedge clk); #1; ovr_clr = 1'b1;
    @(posedge clk); #1; ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_clr", 32'(ovr), 32'd0);
    bus.s_ready = 1'b1;
    drain();

    // Register change after the tick must not affect the sample.
    tick(12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0, 1'b1,
         spec_exp(16'h59F4, 12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0));
    vol = 4'd0; v1 = 12'h000; v2 = 12'h000; v3 = 12'h000; off3 = 1'b1;
    drain();

    // Reset in ACC2 aborts the sample.
    tick(12'hFFF, 12'hFFF, 12'hFFF, 4'd15, 1'b0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    n_reset = 1'b0;
    #1;
    check("abort_valid", 32'(bus.s_valid), 32'd0);
    check("abort_busy",  32'(busy),        32'd0);
    @(posedge clk); #1; n_reset = 1'b1;
    tick(12'h800, 12'h800, 12'h800, 4'd15, 1'b0, 1'b1,
         model(12'h800, 12'h800, 12'h800, 4'd15, 1'b0));
    drain();
    check("post_rst_ovr", 32'(ovr), 32'd0);

    // Random vectors against the model.
    for (int i = 0; i < 8; i++) begin
      ra = 12'($urandom); rb = 12'($urandom); rc = 12'($urandom);
      rv = 4'($urandom); ro = 1'($urandom);
      tick(ra, rb, rc, rv, ro, 1'b1, model(ra, rb, rc, rv, ro));
      drain();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
